// File: rtl/rv32v_writeback_arbiter.sv
// rv32v_writeback_arbiter: buffers four functional-unit result streams in per-source FIFOs and
// round-robins them onto the two-element vector register file write port with ROB completion pulses.
module rv32v_writeback_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int INDEX_W = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   flush,
  input  logic                   wb_stall,
  input  logic [3:0]             src_valid,
  output logic [3:0]             src_ready,
  input  logic [4*INDEX_W-1:0]   src_index,
  input  logic [19:0]            src_vd,
  input  logic [19:0]            src_woffset,
  input  logic [7:0]             src_wen,
  input  logic [255:0]           src_wdata,
  input  logic [3:0]             src_last,
  output logic [1:0]             vrf_wen,
  output logic [4:0]             vrf_vd,
  output logic [4:0]             vrf_woffset,
  output logic [63:0]            vrf_wdata,
  output logic                   done_valid,
  output logic [INDEX_W-1:0]     done_index,
  output logic                   busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef struct packed {
    logic [INDEX_W-1:0] idx;
    logic [4:0]         vd;
    logic [4:0]         wo;
    logic [1:0]         wen;
    logic [63:0]        wd;
    logic               last;
  } ent_t;
  ent_t mem_q [4][FIFO_DEPTH];
  ent_t mem_d [4][FIFO_DEPTH];
  ent_t head;
  logic [PW-1:0] wp_q [4], wp_d [4], rp_q [4], rp_d [4];
  logic [CW-1:0] cnt_q [4], cnt_d [4];
  logic [1:0] rr_q, rr_d, gsel;
  logic [3:0] push, pop, nonempty;
  logic gnt;
  logic [1:0] wen_q, wen_d;
  logic [4:0] vd_q, vd_d, wo_q, wo_d;
  logic [63:0] wd_q, wd_d;
  logic dv_q, dv_d, valid_q;
  logic [INDEX_W-1:0] di_q, di_d;
  always_comb begin
    mem_d = mem_q;
    for (int s = 0; s < 4; s++) begin
      src_ready[s] = cnt_q[s] < CW'(FIFO_DEPTH);
      nonempty[s] = cnt_q[s] != '0;
      push[s] = src_valid[s] & src_ready[s] & ~flush;
      if (push[s])
        mem_d[s][wp_q[s]] = '{idx: src_index[s*INDEX_W +: INDEX_W], vd: src_vd[s*5 +: 5],
                              wo: src_woffset[s*5 +: 5], wen: src_wen[s*2 +: 2],
                              wd: src_wdata[s*64 +: 64], last: src_last[s]};
    end
  end
  // Scan downward so the closest non-empty source at or after rr_q wins.
  always_comb begin
    gnt = 1'b0;
    gsel = rr_q;
    for (int i = 3; i >= 0; i--)
      if (nonempty[rr_q + 2'(i)]) begin
        gnt = 1'b1;
        gsel = rr_q + 2'(i);
      end
    if (wb_stall | flush) gnt = 1'b0;
    pop = gnt ? 4'b0001 << gsel : 4'b0000;
    head = mem_q[gsel][rp_q[gsel]];
    rr_d = flush ? 2'd0 : gnt ? gsel + 2'd1 : rr_q;
    for (int s = 0; s < 4; s++) begin
      wp_d[s] = flush ? '0 : wp_q[s] + PW'(push[s]);
      rp_d[s] = flush ? '0 : rp_q[s] + PW'(pop[s]);
      cnt_d[s] = flush ? '0 : cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
    end
    wen_d = gnt ? head.wen : 2'b00;
    dv_d = gnt & head.last;
    vd_d = gnt ? head.vd : vd_q;
    wo_d = gnt ? head.wo : wo_q;
    wd_d = gnt ? head.wd : wd_q;
    di_d = gnt ? head.idx : di_q;
  end
  always_ff @(posedge CLK)
    mem_q <= mem_d;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      for (int s = 0; s < 4; s++) begin
        wp_q[s] <= '0;
        rp_q[s] <= '0;
        cnt_q[s] <= '0;
      end
      rr_q <= '0;
      wen_q <= '0;
      vd_q <= '0;
      wo_q <= '0;
      wd_q <= '0;
      dv_q <= 1'b0;
      di_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      wen_q <= wen_d;
      vd_q <= vd_d;
      wo_q <= wo_d;
      wd_q <= wd_d;
      dv_q <= dv_d;
      di_q <= di_d;
      valid_q <= gnt;
    end
  assign vrf_wen = wen_q;
  assign vrf_vd = vd_q;
  assign vrf_woffset = wo_q;
  assign vrf_wdata = wd_q;
  assign done_valid = dv_q;
  assign done_index = di_q;
  assign busy = |nonempty | valid_q;
endmodule

// File: doc/rv32v_writeback_arbiter.md
# rv32v_writeback_arbiter

- Sits directly downstream of the RV32V memory stage.
- Accepts per-functional-unit result packets (ALU, MUL, DIV, load/store), each carrying two 32-bit elements, and buffers each source in a small FIFO.
- Round-robin arbitrates the FIFOs onto the single two-element vector register file write port.
- Pulses an instruction-completion index to the reorder buffer when a source's last packet for an instruction is written.

## Interface

Clock and reset: one clock; reset is asynchronous and active-low, ports named CLK and nRST.

Parameters:
- FIFO_DEPTH, 2 — entries per source FIFO; power of two, at least 2.
- INDEX_W, 4 — reorder-buffer index width.

Ports (source s occupies slice s; s=0 ALU, 1 MUL, 2 DIV, 3 LS):
- CLK, in, 1, clock.
- nRST, in, 1, async active-low reset.
- flush, in, 1, drop all buffered and in-flight packets.
- wb_stall, in, 1, freeze dequeue.
- src_valid, in, 4, packet offered.
- src_ready, out, 4, source FIFO can accept.
- src_index, in, 4*INDEX_W, ROB index.
- src_vd, in, 4*5, destination vector register.
- src_woffset, in, 4*5, element offset of element 0.
- src_wen, in, 4*2, per-element write enable; bit1 is element 1.
- src_wdata, in, 4*64, {element1, element0}.
- src_last, in, 4, final packet of the instruction.
- vrf_wen, out, 2, register file element write enables.
- vrf_vd, out, 5, destination register.
- vrf_woffset, out, 5, offset of element 0; element 1 goes to woffset+1.
- vrf_wdata, out, 64, write data.
- done_valid, out, 1, completion pulse.
- done_index, out, INDEX_W, completed ROB index.
- busy, out, 1, any FIFO non-empty or output register valid.

## Operation

- Enqueue:
  - src_ready[s] = (count[s] < FIFO_DEPTH), from registered count only.
  - A full FIFO reports ready=0 even when dequeuing the same cycle.
  - A packet is accepted on a rising edge where src_valid[s] & src_ready[s].
- Per-source FIFO:
  - Circular buffer of {index, vd, woffset, wen, wdata, last}.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - count is 0..FIFO_DEPTH; simultaneous enqueue and dequeue leaves count unchanged.
- Arbitration:
  - Each cycle with !wb_stall & !flush, one non-empty FIFO is granted.
  - Search starts at rr_ptr and scans upward modulo 4.
  - After a grant, rr_ptr = granted+1 mod 4; with no grant, rr_ptr holds.
  - Reset value of rr_ptr is 0.
- Output register:
  - The granted head is popped and registered into vrf_* and done_*.
  - vrf_wen = head.wen, so wen=2'b00 produces no write.
  - done_valid = head.last; done_index = head.index.
  - With no grant, vrf_wen=0 and done_valid=0 on the next cycle; vd, woffset and wdata hold.
- Ordering:
  - Packets from one source leave in acceptance order.
  - No ordering is guaranteed across sources.
- Flush:
  - On the edge with flush=1, all FIFOs are emptied (pointers and counts to 0).
  - vrf_wen and done_valid are cleared and rr_ptr is reset to 0.
  - Packets offered on that edge are dropped.
- Reset (async, mid-operation included): all FIFOs empty, rr_ptr=0; every output is 0 except src_ready=4'b1111.

## Timing

- Minimum latency from accept edge to vrf_wen visible: 2 edges.
  - Edge k: FIFO write.
  - Cycle k..k+1: arbitration.
  - Edge k+1: output register loads.
- No combinational path from src_valid to src_ready or to vrf_*.
- Sustained throughput: one packet per cycle in aggregate; each source gets at least 1 of every 4 grants when all are non-empty.
- wb_stall=1: no pop; outputs drop vrf_wen and done_valid on the next edge; enqueue continues until full.
- flush has priority over wb_stall and over enqueue.

## Test plan

- Latency: after reset, one ALU packet (index=3, vd=5, woffset=4, wen=11, wdata=64'hAAAA_BBBB_CCCC_DDDD, last=1) accepted at edge 0.
  - Required: vrf_wen=11, vd=5, woffset=4, matching data, done_valid=1, done_index=3 after edge 1; all zero after edge 2.
- Round-robin: all four sources offer one packet at the same edge.
  - Required: writes in order ALU, MUL, DIV, LS on 4 consecutive cycles.
  - Then a second burst from MUL and LS only (rr_ptr=0) is written in order MUL, LS.
- Backpressure: wb_stall=1 while DIV offers 3 packets.
  - Required: src_ready[2]=0 after 2 accepts; the third packet is held.
  - After the stall drops: 3 writes in order, ready returns the cycle after the first pop.
- Wrap-around: 10 back-to-back LS packets with woffset 0..9 and no stall.
  - Required: 10 writes with woffset 0..9, in order.
- No-write completion: MUL packet with wen=00, last=1, index=7.
  - Required: vrf_wen=00 with done_valid=1, done_index=7.
- Flush and reset: fill all FIFOs, then assert flush for 1 cycle.
  - Required: no vrf_wen or done_valid afterwards, busy=0, src_ready=1111.
  - Repeat with nRST low mid-burst: outputs are immediately 0.
